// File: rtl/vector_processor.sv
// ----------------------------------------------------------------------------
// vector_processor
//
// Small SIMD vector unit with a word-addressed main memory and a small vector
// register file. One 2-bit opcode is executed on every rising clock edge:
//   0 = ADD   : rf2/rf3 <= lane-wise rf0 + rf1 (64-bit result split LSB/MSB)
//   1 = MUL   : rf2/rf3 <= lane-wise rf0 * rf1 (64-bit result split LSB/MSB)
//   2 = LOAD  : rf[rf_address] <= mem vector mem_address
//   3 = STORE : mem vector mem_address <= rf[rf_address]
//
// Ports:
//   clk          in  1  clock, rising edge
//   rst_n        in  1  synchronous active-low reset; clears rf only
//   opcode       in  2  operation select
//   rf_address   in  2  register index for LOAD/STORE (ignored by ADD/MUL)
//   mem_address  in  5  vector index; vector v covers words v*LANES .. v*LANES+LANES-1
//
// No data outputs: state is observed through hierarchy as main_memory.mem[]
// and rf[][].
//
// Configuration macro:
//   VECTOR_PROCESSOR_SIGNED_EN - when defined, ADD and MUL treat lanes as
//   two's-complement (operands sign-extended to 64 bits). Default is unsigned.
// ----------------------------------------------------------------------------
module vector_processor #(
    parameter int unsigned ELEM_W   = 32,
    parameter int unsigned LANES    = 16,
    parameter int unsigned MEM_VECS = 32,
    parameter int unsigned RF_VECS  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  opcode,
    input  logic [$clog2(RF_VECS)-1:0]  rf_address,
    input  logic [$clog2(MEM_VECS)-1:0] mem_address
);

    localparam int unsigned MemWords = MEM_VECS * LANES;
    localparam int unsigned LaneAw   = $clog2(LANES);
    localparam int unsigned MemAw    = $clog2(MemWords);
    localparam int unsigned WideW    = 2 * ELEM_W;

    typedef enum logic [1:0] {
        OpAdd   = 2'd0,
        OpMul   = 2'd1,
        OpLoad  = 2'd2,
        OpStore = 2'd3
    } op_e;

    op_e op;
    assign op = op_e'(opcode);

    // Vector register file: rf[reg][lane]
    logic [ELEM_W-1:0] rf [RF_VECS][LANES];

    // First word of the addressed memory vector
    logic [MemAw-1:0] base;
    assign base = {mem_address, {LaneAw{1'b0}}};

    // ------------------------------------------------------------------------
    // Lane arithmetic. Operands are widened to 64 bits (zero- or sign-extended);
    // the low 64 bits of the product are then correct for either interpretation.
    // ------------------------------------------------------------------------
    logic [WideW-1:0] op_a [LANES];
    logic [WideW-1:0] op_b [LANES];
    logic [WideW-1:0] sum  [LANES];
    logic [WideW-1:0] prod [LANES];

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
`ifdef VECTOR_PROCESSOR_SIGNED_EN
            op_a[k] = {{ELEM_W{rf[0][k][ELEM_W-1]}}, rf[0][k]};
            op_b[k] = {{ELEM_W{rf[1][k][ELEM_W-1]}}, rf[1][k]};
`else
            op_a[k] = {{ELEM_W{1'b0}}, rf[0][k]};
            op_b[k] = {{ELEM_W{1'b0}}, rf[1][k]};
`endif
            sum[k]  = op_a[k] + op_b[k];
            prod[k] = op_a[k] * op_b[k];
        end
    end

    // ------------------------------------------------------------------------
    // Main memory. Kept in a named scope so benches can reach it as
    // main_memory.mem[] for backdoor preload. Never reset.
    // ------------------------------------------------------------------------
    if (1'b1) begin : main_memory
        logic [ELEM_W-1:0] mem [0:MemWords-1];

        always_ff @(posedge clk) begin
            if (rst_n && (op == OpStore)) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    mem[base + MemAw'(k)] <= rf[rf_address][k];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register file update. All reads use pre-edge values, so back-to-back
    // ops observe the previous op's results.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < RF_VECS; r++) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    rf[r][k] <= '0;
                end
            end
        end else begin
            case (op)
                OpLoad: begin
                    for (int unsigned k = 0; k < LANES; k++) begin
                        rf[rf_address][k] <= main_memory.mem[base + MemAw'(k)];
                    end
                end
                OpAdd: begin
                    for (int unsigned k = 0; k < LANES; k++) begin
                        rf[2][k] <= sum[k][ELEM_W-1:0];
                        rf[3][k] <= sum[k][WideW-1:ELEM_W];
                    end
                end
                OpMul: begin
                    for (int unsigned k = 0; k < LANES; k++) begin
                        rf[2][k] <= prod[k][ELEM_W-1:0];
                        rf[3][k] <= prod[k][WideW-1:ELEM_W];
                    end
                end
                // STORE leaves rf alone; anything unrecognised is a no-op
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_processor.sv
// ----------------------------------------------------------------------------
// tb_vector_processor
//
// Directed self-checking bench for vector_processor. Memory is preloaded via
// hierarchy, ops are driven on the falling edge and results sampled on the
// following falling edge. exp_mem tracks the expected memory image.
// ----------------------------------------------------------------------------
module tb_vector_processor;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_MUL   = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;
    localparam logic [1:0] OP_STORE = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] opcode = OP_LOAD;
    logic [1:0] rf_address = 2'd0;
    logic [4:0] mem_address = 5'd0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_mem [512];

    vector_processor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .rf_address  (rf_address),
        .mem_address (mem_address)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op at the falling edge; it executes on the next rising edge.
    task automatic do_op(input logic [1:0] o, input logic [1:0] r, input logic [4:0] m);
        opcode      = o;
        rf_address  = r;
        mem_address = m;
        @(negedge clk);
    endtask

    task automatic check_rf_zero(input string tag);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 16; k++) begin
                check($sformatf("%s rf%0d[%0d]", tag, r, k), dut.rf[r][k], 32'h0);
            end
        end
    endtask

    task automatic check_mem_range(input string tag, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            check($sformatf("%s mem[%0d]", tag, i), dut.main_memory.mem[i], exp_mem[i]);
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [63:0] p;

        // Preload: words 0..31 = i, words 32..511 = 2**(i%32)
        for (int i = 0; i < 512; i++) begin
            v = (i < 32) ? 32'(i) : (32'd1 << (i % 32));
            dut.main_memory.mem[i] = v;
            exp_mem[i] = v;
        end
        // Vector 10 all ones for the carry / full-scale tests
        for (int k = 0; k < 16; k++) begin
            dut.main_memory.mem[160 + k] = 32'hFFFF_FFFF;
            exp_mem[160 + k] = 32'hFFFF_FFFF;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state: rf cleared, memory preload intact
        check_rf_zero("reset");
        check_mem_range("reset", 0, 511);
        rst_n = 1'b1;

        // T1 ADD
        do_op(OP_LOAD, 2'd0, 5'd0);
        do_op(OP_LOAD, 2'd1, 5'd1);
        do_op(OP_ADD,  2'd0, 5'd0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t1 rf2[%0d]", k), dut.rf[2][k], 32'(16 + 2 * k));
            check($sformatf("t1 rf3[%0d]", k), dut.rf[3][k], 32'h0);
        end
        do_op(OP_STORE, 2'd2, 5'd31);
        do_op(OP_STORE, 2'd3, 5'd30);
        for (int k = 0; k < 16; k++) begin
            exp_mem[496 + k] = 32'(16 + 2 * k);
            exp_mem[480 + k] = 32'h0;
        end
        check_mem_range("t1", 480, 511);

        // T2 MUL: v20 lanes = 2**k, v21 lanes = 2**(16+k)
        do_op(OP_LOAD,  2'd0, 5'd20);
        do_op(OP_LOAD,  2'd1, 5'd21);
        do_op(OP_MUL,   2'd0, 5'd0);
        do_op(OP_STORE, 2'd2, 5'd16);
        do_op(OP_STORE, 2'd3, 5'd15);
        for (int k = 0; k < 16; k++) begin
            p = 64'd1 << (16 + 2 * k);
            exp_mem[256 + k] = p[31:0];
            exp_mem[240 + k] = p[63:32];
        end
        check_mem_range("t2", 240, 271);

        // T3 carry and full-scale MUL with all-ones operands
        do_op(OP_LOAD, 2'd0, 5'd10);
        do_op(OP_LOAD, 2'd1, 5'd10);
        do_op(OP_ADD,  2'd0, 5'd0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t3 add rf2[%0d]", k), dut.rf[2][k], 32'hFFFF_FFFE);
`ifdef VECTOR_PROCESSOR_SIGNED_EN
            check($sformatf("t3 add rf3[%0d]", k), dut.rf[3][k], 32'hFFFF_FFFF);
`else
            check($sformatf("t3 add rf3[%0d]", k), dut.rf[3][k], 32'h0000_0001);
`endif
        end
        do_op(OP_MUL, 2'd0, 5'd0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t3 mul rf2[%0d]", k), dut.rf[2][k], 32'h0000_0001);
`ifdef VECTOR_PROCESSOR_SIGNED_EN
            check($sformatf("t3 mul rf3[%0d]", k), dut.rf[3][k], 32'h0000_0000);
`else
            check($sformatf("t3 mul rf3[%0d]", k), dut.rf[3][k], 32'hFFFF_FFFE);
`endif
        end

        // Back-to-back: LOAD r1 then STORE r1, then STORE v7 then LOAD v7
        do_op(OP_LOAD,  2'd1, 5'd3);
        do_op(OP_STORE, 2'd1, 5'd7);
        do_op(OP_LOAD,  2'd2, 5'd7);
        for (int k = 0; k < 16; k++) begin
            exp_mem[112 + k] = 32'd1 << (16 + k);
            check($sformatf("b2b rf2[%0d]", k), dut.rf[2][k], 32'd1 << (16 + k));
        end
        check_mem_range("b2b", 112, 127);

        // T4 reset mid-sequence with a STORE presented during reset
        do_op(OP_LOAD, 2'd0, 5'd1);
        rst_n       = 1'b0;
        opcode      = OP_STORE;
        rf_address  = 2'd0;
        mem_address = 5'd0;
        @(negedge clk);
        check_rf_zero("t4");
        check_mem_range("t4", 0, 15);
        rst_n = 1'b1;

        // T5 isolation: r1 is zero after reset, so v5 becomes all zero
        do_op(OP_STORE, 2'd1, 5'd5);
        for (int k = 0; k < 16; k++) begin
            exp_mem[80 + k] = 32'h0;
        end
        check_mem_range("t5", 0, 511);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
